rnn_bias_act: RTL and testbench

Post-accumulate stage of the RNN hidden-layer datapath. Consumes one dot-product accumulator per hidden unit, in unit order 0..N_UNITS-1.
- Fetches the matching Q8.8 bias from the bias ROM through a combinational address/data port.
- Adds the bias, rounds to Q8.8 and applies hard-tanh.
- Emits one activation per unit over a valid/ready stream to the hidden-state buffer.

---
 rtl/rnn_bias_act.sv | 235 +++++++++++++++++++++++
 tb/tb_rnn_bias_act.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_bias_act.sv
// rnn_bias_act: post-accumulate stage of the RNN hidden layer.
// Adds the per-unit Q8.8 bias to the accumulator, rounds to Q8.8, applies
// hard-tanh, and streams one activation per hidden unit.
// Optional: define RNN_BIAS_ACT_SATCNT_EN to add the sat_count output, which
// counts delivered activations where the clamp engaged.
module rnn_bias_act #(
   parameter int unsigned N_UNITS = 32,
   parameter int unsigned FRAC    = 8,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ACC_W   = 32,
   localparam int unsigned IDX_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ACC_W-1:0]  in_acc,
   output logic [IDX_W-1:0]  bias_addr,
   input  logic [DATA_W-1:0] bias_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_last
`ifdef RNN_BIAS_ACT_SATCNT_EN
   ,
   output logic [15:0]       sat_count
`endif
);

   // Sum carries one extra bit so acc + shifted bias cannot overflow;
   // rounding adds one more bit so the half-LSB add cannot overflow either.
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned RND_W  = SUM_W + 1;
   localparam int unsigned BPAD_W = SUM_W - DATA_W - FRAC;
   localparam int unsigned LAST_I = N_UNITS - 1;

   localparam logic signed [RND_W-1:0] HALF_LSB = RND_W'(1 << (FRAC - 1));
   localparam logic signed [RND_W-1:0] R_MAX    = RND_W'(1 << FRAC);
   localparam logic signed [RND_W-1:0] R_MIN    = RND_W'(-(1 << FRAC));

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic              s1_valid_q,  s1_valid_d;
   logic [SUM_W-1:0]  s1_sum_q,    s1_sum_d;
   logic [IDX_W-1:0]  s1_idx_q,    s1_idx_d;
   logic              s1_last_q,   s1_last_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;
   logic              out_last_q,  out_last_d;
`ifdef RNN_BIAS_ACT_SATCNT_EN
   logic              out_sat_q,   out_sat_d;
   logic [15:0]       sat_cnt_q,   sat_cnt_d;
`endif

   // ---------------------------------------------------------------------
   // Combinational datapath / handshake signals
   // ---------------------------------------------------------------------
   logic              out_adv_c;
   logic              s1_adv_c;
   logic              accept_c;
   logic              idx_is_last_c;
   logic [SUM_W-1:0]  acc_ext_c;
   logic [SUM_W-1:0]  bias_ext_c;
   logic [SUM_W-1:0]  sum_c;
   logic signed [RND_W-1:0] rnd_c;
   logic signed [RND_W-1:0] r_c;
   logic [DATA_W-1:0] act_c;
   logic              clamp_hi_c;
   logic              clamp_lo_c;

   // Handshake: each stage advances when its successor is empty or advancing;
   // clear blocks intake for the cycle it is asserted.
   always_comb begin
      out_adv_c = 1'b0;
      s1_adv_c  = 1'b0;
      in_ready  = 1'b0;
      accept_c  = 1'b0;

      out_adv_c = !out_valid_q || out_ready;
      s1_adv_c  = s1_valid_q && out_adv_c;
      in_ready  = (!s1_valid_q || out_adv_c) && !clear;
      accept_c  = in_valid && in_ready;
   end

   // Stage 1 arithmetic: sign-extend both operands and align the bias to
   // the accumulator's 2*FRAC fractional bits.
   always_comb begin
      acc_ext_c     = '0;
      bias_ext_c    = '0;
      sum_c         = '0;
      idx_is_last_c = 1'b0;

      acc_ext_c     = {in_acc[ACC_W-1], in_acc};
      bias_ext_c    = {{BPAD_W{bias_data[DATA_W-1]}}, bias_data, {FRAC{1'b0}}};
      sum_c         = acc_ext_c + bias_ext_c;
      idx_is_last_c = (idx_q == IDX_W'(LAST_I));
   end

   // Stage 2 arithmetic: round-half-up to Q8.8, then clamp the full-width
   // result to [-1.0, +1.0] so large sums never wrap into range.
   always_comb begin
      rnd_c      = '0;
      r_c        = '0;
      act_c      = '0;
      clamp_hi_c = 1'b0;
      clamp_lo_c = 1'b0;

      rnd_c      = $signed({s1_sum_q[SUM_W-1], s1_sum_q}) + HALF_LSB;
      r_c        = rnd_c >>> FRAC;
      clamp_hi_c = (r_c > R_MAX);
      clamp_lo_c = (r_c < R_MIN);
      if (clamp_hi_c) begin
         act_c = DATA_W'(R_MAX);
      end else if (clamp_lo_c) begin
         act_c = DATA_W'(R_MIN);
      end else begin
         act_c = DATA_W'(r_c);
      end
   end

   // Unit index: advances per accepted beat, wraps at the end of the frame.
   always_comb begin
      idx_d = idx_q;
      if (clear) begin
         idx_d = '0;
      end else if (accept_c) begin
         idx_d = idx_is_last_c ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Stage 1 next state: capture sum and index tag on accept.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sum_d   = s1_sum_q;
      s1_idx_d   = s1_idx_q;
      s1_last_d  = s1_last_q;
      if (clear) begin
         s1_valid_d = 1'b0;
      end else if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_sum_d   = sum_c;
         s1_idx_d   = idx_q;
         s1_last_d  = idx_is_last_c;
      end else if (s1_adv_c) begin
         s1_valid_d = 1'b0;
      end
   end

   // Output stage next state: payload only changes when the stage advances.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
`ifdef RNN_BIAS_ACT_SATCNT_EN
      out_sat_d   = out_sat_q;
`endif
      if (clear) begin
         out_valid_d = 1'b0;
      end else if (out_adv_c) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d  = act_c;
            out_index_d = s1_idx_q;
            out_last_d  = s1_last_q;
`ifdef RNN_BIAS_ACT_SATCNT_EN
            out_sat_d   = clamp_hi_c || clamp_lo_c;
`endif
         end
      end
   end

`ifdef RNN_BIAS_ACT_SATCNT_EN
   // Saturation counter: counts delivered clamped beats, sticks at all-ones.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (clear) begin
         sat_cnt_d = '0;
      end else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'(1);
      end
   end

   // Saturation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sat_q <= 1'b0;
         sat_cnt_q <= '0;
      end else begin
         out_sat_q <= out_sat_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_count = sat_cnt_q;
`endif

   // Pipeline and index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_idx_q    <= '0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         s1_valid_q  <= s1_valid_d;
         s1_sum_q    <= s1_sum_d;
         s1_idx_q    <= s1_idx_d;
         s1_last_q   <= s1_last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   // Output drive.
   assign bias_addr = idx_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_rnn_bias_act.sv
// Testbench for rnn_bias_act: table-driven vectors plus stall/clear/frame
// sequences, all checked through an expected-result scoreboard.
// Build with RNN_BIAS_ACT_SATCNT_EN defined to also exercise sat_count.
module tb_rnn_bias_act;

   localparam int unsigned N     = 32;
   localparam int unsigned IDX_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_acc;
   logic [IDX_W-1:0]  bias_addr;
   logic [15:0]       bias_data;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;
`ifdef RNN_BIAS_ACT_SATCNT_EN
   logic [15:0]       sat_count;
`endif

   always #5 clk = ~clk;

   rnn_bias_act dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .bias_addr (bias_addr),
      .bias_data (bias_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
`ifdef RNN_BIAS_ACT_SATCNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   // Bias ROM model, combinational read.
   logic [15:0] rom [N];
   assign bias_data = rom[bias_addr];

   typedef struct packed {
      logic [15:0]      data;
      logic [IDX_W-1:0] idx;
      logic             last;
   } exp_t;

   typedef struct {
      logic [31:0] acc;
      logic [15:0] bias;
      logic [15:0] exp_data;
   } vec_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   vec_t        vecs[16];
   int          checks   = 0;
   int          failures = 0;
   int          tb_idx   = 0;
   int          acc_cnt  = 0;
   int          stall_start;
   logic [15:0] drv_exp  = '0;
   bit          drv_use_exp = 1'b0;
   bit          held_v   = 1'b0;
   logic [22:0] held_val = '0;

   // Reference: bias add, round-half-up, hard-tanh clamp.
   function automatic logic [15:0] model(input logic [31:0] acc, input logic [15:0] bias);
      longint s;
      longint r;
      s = longint'($signed(acc)) + longint'($signed(bias)) * 256;
      r = (s + 128) >>> 8;
      if (r > 256) r = 256;
      else if (r < -256) r = -256;
      return r[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: push expectations on accept, pop/compare on delivery,
   // and check that a stalled output holds still.
   always @(negedge clk) begin
      if (!rst_n || clear) begin
         sb_q.delete();
         tb_idx = 0;
         held_v = 1'b0;
      end else begin
         if (held_v)
            chk("hold_stable", {out_valid, out_data, out_index, out_last}, {9'd0, held_val});
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
               mon_e = sb_q.pop_front();
               chk("out_beat", {out_data, out_index, out_last}, {mon_e.data, mon_e.idx, mon_e.last});
            end
         end
         held_v   = out_valid && !out_ready;
         held_val = {out_valid, out_data, out_index, out_last};
         if (in_valid && in_ready) begin
            chk("bias_addr", 32'(bias_addr), 32'(tb_idx));
            mon_e.data = drv_use_exp ? drv_exp : model(in_acc, bias_data);
            mon_e.idx  = IDX_W'(tb_idx);
            mon_e.last = (tb_idx == N - 1);
            sb_q.push_back(mon_e);
            acc_cnt++;
            tb_idx = (tb_idx == N - 1) ? 0 : tb_idx + 1;
         end
      end
   end

   // Present one beat and hold it until accepted (bounded).
   task automatic send(input logic [31:0] acc, input bit use_exp,
                       input logic [15:0] expv, input bit want_ready);
      int n = 0;
      in_valid    = 1'b1;
      in_acc      = acc;
      drv_use_exp = use_exp;
      drv_exp     = expv;
      @(negedge clk);
      if (want_ready) chk("in_ready_stream", 32'(in_ready), 32'd1);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=in_ready_low required=accept");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      chk("in_ready_clear", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h0000_8000, 16'hFFC1, 16'h0041};
      vecs[1]  = '{32'h0002_0000, 16'h0000, 16'h0100};
      vecs[2]  = '{32'hFFFE_0000, 16'h0000, 16'hFF00};
      vecs[3]  = '{32'hFFFF_FF80, 16'h0000, 16'h0000};
      vecs[4]  = '{32'h0001_0000, 16'h0000, 16'h0100};
      vecs[5]  = '{32'h0001_0080, 16'h0000, 16'h0100};
      vecs[6]  = '{32'hFFFF_0000, 16'h0000, 16'hFF00};
      vecs[7]  = '{32'hFFFE_FF80, 16'h0000, 16'hFF00};
      vecs[8]  = '{32'hFFFE_FF7F, 16'h0000, 16'hFF00};
      vecs[9]  = '{32'h7FFF_FFFF, 16'h7FFF, 16'h0100};
      vecs[10] = '{32'h8000_0000, 16'h8000, 16'hFF00};
      vecs[11] = '{32'h0000_017F, 16'h0001, 16'h0002};
      vecs[12] = '{32'h0000_0080, 16'h0000, 16'h0001};
      vecs[13] = '{32'hFFFF_FF7F, 16'h0000, 16'hFFFF};
      vecs[14] = '{32'h0000_0000, 16'h00FF, 16'h00FF};
      vecs[15] = '{32'h0000_0000, 16'h0101, 16'h0100};
      for (int i = 0; i < N; i++) rom[i] = (i < 16) ? vecs[i].bias : 16'h0000;

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_acc = '0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_bias_addr", 32'(bias_addr), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table vectors; the first one also checks the 2-cycle latency
      send(vecs[0].acc, 1'b1, vecs[0].exp_data, 1'b1);
      @(negedge clk);
      chk("latency_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_c2", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 1; i < 16; i++) send(vecs[i].acc, 1'b1, vecs[i].exp_data, 1'b1);
      drain();

      // Full frame back-to-back plus one wrap beat
      do_clear();
      for (int i = 0; i < N; i++) rom[i] = 16'(int'($urandom_range(0, 1024)) - 512);
      for (int i = 0; i < N + 1; i++) begin
         logic [31:0] a;
         a = (i % 3 == 0) ? 32'($urandom) : 32'(int'($urandom_range(0, 196608)) - 98304);
         send(a, 1'b0, 16'h0, 1'b1);
      end
      drain();

      // Downstream stall mid-stream
      fork
         begin
            for (int i = 0; i < 14; i++)
               send(32'(int'($urandom_range(0, 131072)) - 65536), 1'b0, 16'h0, 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready   = 1'b0;
            stall_start = acc_cnt;
            repeat (5) @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_accepts_le2", 32'((acc_cnt - stall_start) <= 2), 32'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Clear with two beats in flight at unit 10
      do_clear();
      for (int i = 0; i < 8; i++) send(32'h0000_1000 * i, 1'b0, 16'h0, 1'b1);
      drain();
      out_ready = 1'b0;
      send(32'h0000_4000, 1'b0, 16'h0, 1'b0);
      send(32'h0000_5000, 1'b0, 16'h0, 1'b0);
      chk("pre_clear_addr", 32'(bias_addr), 32'd10);
      in_valid = 1'b1;
      in_acc   = 32'h0000_0300;
      drv_use_exp = 1'b0;
      do_clear();
      @(negedge clk);
      chk("clear_out_valid", 32'(out_valid), 32'd0);
      chk("clear_bias_addr", 32'(bias_addr), 32'd0);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

`ifdef RNN_BIAS_ACT_SATCNT_EN
      // Saturation counter: three clamped outputs in a short frame
      do_clear();
      for (int i = 0; i < N; i++) rom[i] = 16'h0000;
      @(negedge clk);
      chk("sat_after_clear0", 32'(sat_count), 32'd0);
      @(posedge clk);
      #1;
      send(32'h0002_0000, 1'b0, 16'h0, 1'b1);
      send(32'h0000_0100, 1'b0, 16'h0, 1'b1);
      send(32'hFFFE_0000, 1'b0, 16'h0, 1'b1);
      send(32'h0000_0000, 1'b0, 16'h0, 1'b1);
      send(32'h0001_0080, 1'b0, 16'h0, 1'b1);
      drain();
      @(negedge clk);
      chk("sat_count_3", 32'(sat_count), 32'd3);
      @(posedge clk);
      #1;
      do_clear();
      @(negedge clk);
      chk("sat_count_clear", 32'(sat_count), 32'd0);
      @(posedge clk);
      #1;
`endif

      chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
